// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit layout, port numbering and arbiter state encoding.
package noc_pkg;

    localparam int FLIT_W    = 34;
    localparam int HEAD_BIT  = FLIT_W - 1;
    localparam int TAIL_BIT  = FLIT_W - 2;
    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_E = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping past NPORT-1.
module rr_arbiter #(
    parameter int NPORT = 5,
    parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NPORT-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam int SUM_W = IDX_W + 1;

    logic [2*NPORT-1:0] req_dbl;
    logic [NPORT-1:0]   req_rot;
    logic [IDX_W-1:0]   offset;
    logic [SUM_W-1:0]   sum;

    // Rotating a doubled copy puts the request at ptr into bit 0.
    assign req_dbl = {req, req};
    assign req_rot = NPORT'(req_dbl >> ptr);

    always_comb begin
        offset      = '0;
        grant_valid = 1'b0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset      = IDX_W'(k);
                grant_valid = 1'b1;
            end
        end
    end

    assign sum       = SUM_W'(ptr) + SUM_W'(offset);
    assign grant_idx = (sum >= SUM_W'(NPORT)) ? IDX_W'(sum - SUM_W'(NPORT)) : IDX_W'(sum);

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_onehot
            assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/output_arbiter.sv
// Switch arbiter for one router output: wormhole lock per packet, round-robin between
// packets, and a registered valid/ready output stage that sustains one flit per cycle.
module output_arbiter #(
    parameter int FLIT_W = 34,
    parameter int NPORT  = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORT-1:0]             req_i,
    input  logic [NPORT-1:0][FLIT_W-1:0] flit_i,
    output logic [NPORT-1:0]             pop_req_o,
    output logic [FLIT_W-1:0]            data_o,
    output logic                         valid_o,
    input  logic                         ready_i
);

    import noc_pkg::*;

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int HEAD  = FLIT_W - 1;
    localparam int TAIL  = FLIT_W - 2;

    arb_state_e        state_reg, state_next;
    logic [IDX_W-1:0]  grant_reg, grant_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [FLIT_W-1:0] data_reg;
    logic              valid_reg;

    logic [NPORT-1:0]  arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [NPORT-1:0]  lock_onehot;
    logic [NPORT-1:0]  sel_onehot;
    logic [FLIT_W-1:0] sel_flit;
    logic              sel_req;
    logic              out_free;
    logic              load;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(NPORT - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_i),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign lock_onehot[gi] = (grant_reg == IDX_W'(gi));
            // Held low during reset so a reset never pops an upstream queue.
            assign pop_req_o[gi]   = load && !rst && sel_onehot[gi];
        end
    endgenerate

    assign out_free   = !valid_reg || ready_i;
    assign sel_onehot = (state_reg == ST_LOCK) ? lock_onehot : arb_grant;
    assign sel_req    = |(req_i & sel_onehot);

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel_onehot[i]) begin
                sel_flit = sel_flit | flit_i[i];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rr_ptr_next = rr_ptr_reg;
        load        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (out_free && arb_valid) begin
                    load = 1'b1;
                    if (sel_flit[HEAD] && !sel_flit[TAIL]) begin
                        state_next = ST_LOCK;
                        grant_next = arb_idx;
                    end else if (sel_flit[HEAD]) begin
                        rr_ptr_next = wrap_inc(arb_idx);
                    end
                    // A headless flit here is a protocol error: forwarded, never locked.
                end
            end
            ST_LOCK: begin
                if (out_free && sel_req) begin
                    load = 1'b1;
                    if (sel_flit[TAIL]) begin
                        state_next  = ST_IDLE;
                        rr_ptr_next = wrap_inc(grant_reg);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= IDX_W'(PORT_N);
            data_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rr_ptr_reg <= rr_ptr_next;
            if (load) begin
                data_reg  <= sel_flit;
                valid_reg <= 1'b1;
            end else if (ready_i) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data_o  = data_reg;
    assign valid_o = valid_reg;

endmodule
